// File: rtl/btn_event_pkg.sv
// Shared types and helpers for the button event classifier.
// State encoding and the ms-to-cycles conversion used to size the hold/double-click timers.
package btn_event_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HELD,
        LONG_HELD,
        WAIT_2ND,
        HELD_2ND
    } btn_state_t;

    function automatic int ms_to_cycles(input int freq_hz, input int ms);
        return (freq_hz / 1000) * ms;
    endfunction

endpackage

// File: rtl/btn_edge_det.sv
// Edge detector for the debounced button level.
// btn_q tracks btn_i even during reset, so a button held through reset never produces a rise.
module btn_edge_det (
    input  logic clk_i,
    input  logic btn_i,
    output logic rise_o,
    output logic fall_o
);

    logic btn_q;

    always_ff @(posedge clk_i) begin
        btn_q <= btn_i;
    end

    assign rise_o = btn_i & ~btn_q;
    assign fall_o = ~btn_i & btn_q;

endmodule

// File: rtl/btn_event_fsm.sv
// Classifies a debounced button into press/release/short/long/double one-cycle pulses.
// Define BTN_DOUBLE_EN to enable double-click detection (short press then waits out the window).
module btn_event_fsm
    import btn_event_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int LONG_MS     = 1000,
    parameter int DBL_MS      = 300
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic pressed_o,
    output logic press_o,
    output logic release_o,
    output logic short_o,
    output logic long_o,
    output logic double_o
);

    localparam int LONG_CYC = ms_to_cycles(CLK_FREQ_HZ, LONG_MS);
    localparam int DBL_CYC  = ms_to_cycles(CLK_FREQ_HZ, DBL_MS);
`ifdef BTN_DOUBLE_EN
    localparam int CNT_MAX  = (LONG_CYC > DBL_CYC) ? LONG_CYC : DBL_CYC;
`else
    localparam int CNT_MAX  = LONG_CYC;
`endif
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
`ifdef BTN_DOUBLE_EN
    localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_CYC - 1);
`endif

    if (LONG_CYC < 2 || DBL_CYC < 2) begin : g_bad_cfg
        $error("btn_event_fsm: LONG_CYC and DBL_CYC must both be >= 2");
    end

    btn_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             rise;
    logic             fall;

    btn_edge_det u_edge (
        .clk_i  (clk_i),
        .btn_i  (btn_i),
        .rise_o (rise),
        .fall_o (fall)
    );

    // cnt restarts at 0 on every state change; later non-blocking writes override the increment.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            cnt       <= '0;
            pressed_o <= 1'b0;
            press_o   <= 1'b0;
            release_o <= 1'b0;
            short_o   <= 1'b0;
            long_o    <= 1'b0;
`ifdef BTN_DOUBLE_EN
            double_o  <= 1'b0;
`endif
        end else begin
            press_o   <= 1'b0;
            release_o <= 1'b0;
            short_o   <= 1'b0;
            long_o    <= 1'b0;
`ifdef BTN_DOUBLE_EN
            double_o  <= 1'b0;
`endif
            if (cnt != CNT_SAT) begin
                cnt <= cnt + CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    if (rise) begin
                        press_o   <= 1'b1;
                        pressed_o <= 1'b1;
                        cnt       <= '0;
                        state     <= HELD;
                    end
                end

                // A fall landing on the long-press cycle still counts as long; release is not lost.
                HELD: begin
                    if (cnt == LONG_LAST) begin
                        long_o <= 1'b1;
                        cnt    <= '0;
                        if (fall) begin
                            release_o <= 1'b1;
                            pressed_o <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            state <= LONG_HELD;
                        end
                    end else if (fall) begin
                        release_o <= 1'b1;
                        pressed_o <= 1'b0;
                        cnt       <= '0;
`ifdef BTN_DOUBLE_EN
                        state     <= WAIT_2ND;
`else
                        short_o   <= 1'b1;
                        state     <= IDLE;
`endif
                    end
                end

                LONG_HELD: begin
                    if (fall) begin
                        release_o <= 1'b1;
                        pressed_o <= 1'b0;
                        cnt       <= '0;
                        state     <= IDLE;
                    end
                end

`ifdef BTN_DOUBLE_EN
                // A rise in the timeout cycle takes priority: the click becomes a double candidate.
                WAIT_2ND: begin
                    if (rise) begin
                        press_o   <= 1'b1;
                        pressed_o <= 1'b1;
                        cnt       <= '0;
                        state     <= HELD_2ND;
                    end else if (cnt == DBL_LAST) begin
                        short_o <= 1'b1;
                        cnt     <= '0;
                        state   <= IDLE;
                    end
                end

                HELD_2ND: begin
                    if (cnt == LONG_LAST) begin
                        long_o <= 1'b1;
                        cnt    <= '0;
                        if (fall) begin
                            release_o <= 1'b1;
                            pressed_o <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            state <= LONG_HELD;
                        end
                    end else if (fall) begin
                        release_o <= 1'b1;
                        double_o  <= 1'b1;
                        pressed_o <= 1'b0;
                        cnt       <= '0;
                        state     <= IDLE;
                    end
                end
`endif

                default: begin
                    pressed_o <= 1'b0;
                    cnt       <= '0;
                    state     <= IDLE;
                end
            endcase
        end
    end

`ifndef BTN_DOUBLE_EN
    assign double_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(press_o && release_o));
            assert ($onehot0({short_o, long_o, double_o}));
        end
    end

endmodule

// File: tb/tb_btn_event_fsm.sv
// Scoreboard bench for btn_event_fsm: stimulus pushes expected pulses by cycle, a monitor pops them.
// Covers both builds; BTN_DOUBLE_EN selects the double-click expectations.
module tb_btn_event_fsm;

    localparam int CLK_HZ = 10_000;
    localparam int LC     = (CLK_HZ / 1000) * 5;
    localparam int DC     = (CLK_HZ / 1000) * 2;

    localparam logic [4:0] EV_P = 5'b10000;
    localparam logic [4:0] EV_R = 5'b01000;
    localparam logic [4:0] EV_S = 5'b00100;
    localparam logic [4:0] EV_L = 5'b00010;
    localparam logic [4:0] EV_D = 5'b00001;

    typedef struct {
        int         cyc;
        logic [4:0] ev;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic btn;
    logic pressed_o, press_o, release_o, short_o, long_o, double_o;

    int   cyc = 0;
    int   n_assert = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;
    exp_t sb[$];

    btn_event_fsm #(
        .CLK_FREQ_HZ (CLK_HZ),
        .LONG_MS     (5),
        .DBL_MS      (2)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .btn_i     (btn),
        .pressed_o (pressed_o),
        .press_o   (press_o),
        .release_o (release_o),
        .short_o   (short_o),
        .long_o    (long_o),
        .double_o  (double_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic push_ev(input int c, input logic [4:0] ev);
        int pos;
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].cyc == c) begin
                sb[i].ev = sb[i].ev | ev;
                return;
            end
        end
        pos = sb.size();
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc > c) pos = i;
        end
        sb.insert(pos, '{c, ev});
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        logic [4:0] ev;
        if (mon_en) begin
            ev = {press_o, release_o, short_o, long_o, double_o};
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                check($sformatf("missing_ev_at_%0d", sb[0].cyc), 32'(0), 32'(sb[0].ev));
                sb.delete(0);
            end
            if (ev != 5'b0) begin
                if (sb.size() > 0 && sb[0].cyc == cyc) begin
                    check("event", 32'(ev), 32'(sb[0].ev));
                    sb.delete(0);
                end else begin
                    check("unexpected_ev", 32'(ev), 32'(0));
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        btn = 1'b0;
        wait_cyc(3);
        check("reset_outputs", 32'({pressed_o, press_o, release_o, short_o, long_o, double_o}), 32'(0));
        rst = 1'b0;
        wait_cyc(1);
        mon_en = 1'b1;

        // Short press of 10 cycles
        btn = 1'b1;
        push_ev(cyc + 1, EV_P);
        wait_cyc(1);
        check("pressed_in_held", 32'(pressed_o), 32'(1));
        wait_cyc(9);
        btn = 1'b0;
`ifdef BTN_DOUBLE_EN
        push_ev(cyc + 1, EV_R);
        push_ev(cyc + 1 + DC, EV_S);
`else
        push_ev(cyc + 1, EV_R | EV_S);
`endif
        wait_cyc(DC + 10);
        check("pressed_idle", 32'(pressed_o), 32'(0));

        // Long press held 80 cycles
        btn = 1'b1;
        push_ev(cyc + 1, EV_P);
        push_ev(cyc + 1 + LC, EV_L);
        wait_cyc(LC + 5);
        check("pressed_long_held", 32'(pressed_o), 32'(1));
        wait_cyc(80 - LC - 5);
        btn = 1'b0;
        push_ev(cyc + 1, EV_R);
        wait_cyc(DC + 10);

`ifdef BTN_DOUBLE_EN
        // Double click: press 5, gap 8, press 5
        btn = 1'b1;
        push_ev(cyc + 1, EV_P);
        wait_cyc(5);
        btn = 1'b0;
        push_ev(cyc + 1, EV_R);
        wait_cyc(8);
        btn = 1'b1;
        push_ev(cyc + 1, EV_P);
        wait_cyc(5);
        btn = 1'b0;
        push_ev(cyc + 1, EV_R | EV_D);
        wait_cyc(DC + 10);

        // Second rise sampled exactly on the double-click timeout cycle
        btn = 1'b1;
        push_ev(cyc + 1, EV_P);
        wait_cyc(5);
        btn = 1'b0;
        push_ev(cyc + 1, EV_R);
        wait_cyc(DC);
        btn = 1'b1;
        push_ev(cyc + 1, EV_P);
        wait_cyc(1);
        check("pressed_held_2nd", 32'(pressed_o), 32'(1));
        wait_cyc(4);
        btn = 1'b0;
        push_ev(cyc + 1, EV_R | EV_D);
        wait_cyc(DC + 10);
`endif

        // Button held through reset: no press until a fresh rise
        btn = 1'b1;
        rst = 1'b1;
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(10);
        check("pressed_after_rst_hold", 32'(pressed_o), 32'(0));
        btn = 1'b0;
        wait_cyc(10);
        btn = 1'b1;
        push_ev(cyc + 1, EV_P);
        wait_cyc(5);
        btn = 1'b0;
`ifdef BTN_DOUBLE_EN
        push_ev(cyc + 1, EV_R);
        push_ev(cyc + 1 + DC, EV_S);
`else
        push_ev(cyc + 1, EV_R | EV_S);
`endif
        wait_cyc(DC + 10);

`ifdef BTN_DOUBLE_EN
        // Reset pulse while waiting for a second click (cnt = 10) discards the pending short
        btn = 1'b1;
        push_ev(cyc + 1, EV_P);
        wait_cyc(5);
        btn = 1'b0;
        push_ev(cyc + 1, EV_R);
        wait_cyc(11);
        rst = 1'b1;
        wait_cyc(1);
        check("outputs_after_mid_rst",
              32'({pressed_o, press_o, release_o, short_o, long_o, double_o}), 32'(0));
        rst = 1'b0;
        wait_cyc(DC + 20);
`else
        // Reset pulse mid-hold: no release and no long press afterwards
        btn = 1'b1;
        push_ev(cyc + 1, EV_P);
        wait_cyc(20);
        rst = 1'b1;
        wait_cyc(1);
        check("outputs_after_mid_rst",
              32'({pressed_o, press_o, release_o, short_o, long_o, double_o}), 32'(0));
        rst = 1'b0;
        wait_cyc(LC + 10);
        btn = 1'b0;
        wait_cyc(DC + 10);
`endif

        wait_cyc(5);
        check("scoreboard_empty", 32'(sb.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
